foh_interp_sequencer: RTL and testbench

//  Sequencer for the FOH interpolation datapath (RegA/RegB/RegC, slope shift, accumulator).

---
 rtl/foh_interp_sequencer_if.sv | 32 +++
 rtl/foh_interp_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_foh_interp_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/foh_interp_sequencer_if.sv
// rtl/foh_interp_sequencer_if.sv - run control, upstream handshake and datapath control bundle for the FOH sequencer
interface foh_interp_sequencer_if #(
    parameter int L_LOG2 = 3,
    parameter int DIV_W  = 8
);
    logic              ENABLE;
    logic [DIV_W-1:0]  RATE_DIV;
    logic              IN_VALID;
    logic              IN_ACK;
    logic              LOAD_A;
    logic              LOAD_B;
    logic              INIT_C;
    logic              LOAD_C;
    logic              SHIFT;
    logic              ADVANCE;
    logic              OUT_STROBE;
    logic [L_LOG2-1:0] STEP_IDX;
    logic              BUSY;
    logic              UNDERRUN;

    modport master (
        input  ENABLE, RATE_DIV, IN_VALID,
        output IN_ACK, LOAD_A, LOAD_B, INIT_C, LOAD_C, SHIFT, ADVANCE,
        output OUT_STROBE, STEP_IDX, BUSY, UNDERRUN
    );

    modport slave (
        output ENABLE, RATE_DIV, IN_VALID,
        input  IN_ACK, LOAD_A, LOAD_B, INIT_C, LOAD_C, SHIFT, ADVANCE,
        input  OUT_STROBE, STEP_IDX, BUSY, UNDERRUN
    );
endinterface

// File: rtl/foh_interp_sequencer.sv
// rtl/foh_interp_sequencer.sv - FOH interpolation sequencer: priming, rate divider, per-segment step/advance control
// Optional FOH_SEQ_UNDERRUN_HOLD_EN: on underrun keep strobing a held output instead of dropping to IDLE.
module foh_interp_sequencer #(
    parameter int L_LOG2 = 3,
    parameter int DIV_W  = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    foh_interp_sequencer_if.master seq
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_PRIME_A,
        S_WAIT_B,
        S_PRIME_B,
        S_SETTLE1,
        S_SETTLE2,
        S_LOADC,
        S_RUN,
        S_HOLD
    } state_t;

    localparam logic [L_LOG2-1:0] STEP_MAX = '1;
    localparam logic [DIV_W-1:0]  R_MIN    = DIV_W'(3);

    state_t            state_q, state_d;
    logic [L_LOG2-1:0] step_q, step_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              first_q, first_d;
    logic              underrun_q, underrun_d;

    logic [DIV_W-1:0]  r_eff;
    logic              div_active;
    logic              tick;
    logic              in_ack, load_a, load_b, init_c, load_c, shift, advance, out_strobe;

    // A period of at least 4 cycles leaves room for SETTLE1/SETTLE2/LOADC between an advance and the next tick.
    assign r_eff = (seq.RATE_DIV < R_MIN) ? R_MIN : seq.RATE_DIV;

    // first_q marks the priming pass: the divider stays parked until LOADC seeds it.
    assign div_active = !first_q &&
                        (state_q == S_SETTLE1 || state_q == S_SETTLE2 || state_q == S_LOADC ||
                         state_q == S_RUN     || state_q == S_HOLD);
    assign tick       = div_active && (div_q == '0);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        div_d      = div_q;
        first_d    = first_q;
        underrun_d = underrun_q;
        in_ack     = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        init_c     = 1'b0;
        load_c     = 1'b0;
        shift      = 1'b0;
        advance    = 1'b0;
        out_strobe = 1'b0;

        if (div_active) begin
            div_d = tick ? r_eff : div_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                step_d = '0;
                div_d  = '0;
                if (seq.IN_VALID) begin
                    state_d = S_PRIME_A;
                end
            end
            S_PRIME_A: begin
                in_ack  = 1'b1;
                load_a  = 1'b1;
                state_d = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (seq.IN_VALID) begin
                    state_d = S_PRIME_B;
                end
            end
            S_PRIME_B: begin
                in_ack  = 1'b1;
                load_b  = 1'b1;
                init_c  = 1'b1;
                first_d = 1'b1;
                state_d = S_SETTLE1;
            end
            S_SETTLE1: state_d = S_SETTLE2;
            S_SETTLE2: state_d = S_LOADC;
            S_LOADC: begin
                load_c  = 1'b1;
                init_c  = 1'b1;
                step_d  = '0;
                if (first_q) begin
                    div_d   = r_eff;
                    first_d = 1'b0;
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                if (tick) begin
                    out_strobe = 1'b1;
                    if (step_q != STEP_MAX) begin
                        shift  = 1'b1;
                        step_d = step_q + 1'b1;
                    end else if (seq.IN_VALID) begin
                        advance = 1'b1;
                        load_a  = 1'b1;
                        load_b  = 1'b1;
                        in_ack  = 1'b1;
                        init_c  = 1'b1;
                        state_d = S_SETTLE1;
                    end else begin
                        underrun_d = 1'b1;
`ifdef FOH_SEQ_UNDERRUN_HOLD_EN
                        state_d    = S_HOLD;
`else
                        state_d    = S_IDLE;
`endif
                    end
                end
            end
`ifdef FOH_SEQ_UNDERRUN_HOLD_EN
            S_HOLD: begin
                out_strobe = tick;
                if (seq.IN_VALID) begin
                    advance = 1'b1;
                    load_a  = 1'b1;
                    load_b  = 1'b1;
                    in_ack  = 1'b1;
                    init_c  = 1'b1;
                    state_d = S_SETTLE1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Dropping ENABLE overrides everything: no pop, no datapath action, clean return to IDLE.
        if (!seq.ENABLE) begin
            state_d    = S_IDLE;
            step_d     = '0;
            div_d      = '0;
            first_d    = 1'b0;
            underrun_d = 1'b0;
            in_ack     = 1'b0;
            load_a     = 1'b0;
            load_b     = 1'b0;
            init_c     = 1'b0;
            load_c     = 1'b0;
            shift      = 1'b0;
            advance    = 1'b0;
            out_strobe = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            div_q      <= '0;
            first_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            div_q      <= div_d;
            first_q    <= first_d;
            underrun_q <= underrun_d;
        end
    end

    assign seq.IN_ACK     = in_ack;
    assign seq.LOAD_A     = load_a;
    assign seq.LOAD_B     = load_b;
    assign seq.INIT_C     = init_c;
    assign seq.LOAD_C     = load_c;
    assign seq.SHIFT      = shift;
    assign seq.ADVANCE    = advance;
    assign seq.OUT_STROBE = out_strobe;
    assign seq.STEP_IDX   = step_q;
    assign seq.BUSY       = (state_q != S_IDLE);
    assign seq.UNDERRUN   = underrun_q;
endmodule

// File: tb/tb_foh_interp_sequencer.sv
// tb/tb_foh_interp_sequencer.sv - directed vector bench for foh_interp_sequencer
module tb_foh_interp_sequencer;
    logic CLOCK = 1'b0;
    logic RESET;

    always #5 CLOCK = ~CLOCK;

    foh_interp_sequencer_if #(.L_LOG2(3), .DIV_W(8)) bus ();

    foh_interp_sequencer #(.L_LOG2(3), .DIV_W(8)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .seq   (bus.master)
    );

    // {IN_ACK, LOAD_A, LOAD_B, INIT_C, LOAD_C, SHIFT, ADVANCE, OUT_STROBE, BUSY, UNDERRUN}
    logic [9:0] outs;
    assign outs = {bus.IN_ACK, bus.LOAD_A, bus.LOAD_B, bus.INIT_C, bus.LOAD_C,
                   bus.SHIFT, bus.ADVANCE, bus.OUT_STROBE, bus.BUSY, bus.UNDERRUN};

    typedef struct {
        logic       en;
        logic       iv;
        logic [7:0] rd;
        logic [9:0] exp_outs;
        logic [2:0] exp_step;
    } vec_t;

    vec_t tbl[11];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive just after the edge, sample at the falling edge.
    task automatic cyc(input logic rst, input logic en, input logic iv, input logic [7:0] rd);
        @(posedge CLOCK);
        #1;
        RESET        = rst;
        bus.ENABLE   = en;
        bus.IN_VALID = iv;
        bus.RATE_DIV = rd;
        @(negedge CLOCK);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'd9);
        cyc(1'b1, 1'b0, 1'b0, 8'd9);
    endtask

    // Reset then prime with IN_VALID held: cycles c0..c6, LOADC on c6.
    task automatic start_run(input logic [7:0] rd);
        do_reset();
        repeat (7) cyc(1'b0, 1'b1, 1'b1, rd);
    endtask

    // Per-cycle schedule: strobes at first + n*period, shift on steps 0..6, advance on step 7.
    task automatic run_seg(input string tag, input int c0, input int c1, input int first,
                           input int period, input int base_k, input logic [7:0] rd);
        for (int c = c0; c <= c1; c++) begin
            logic st;
            int   k;
            logic adv;
            logic shf;
            cyc(1'b0, 1'b1, 1'b1, rd);
            st  = (c >= first) && (((c - first) % period) == 0);
            k   = st ? base_k + (c - first) / period : 0;
            adv = st && ((k % 8) == 7);
            shf = st && ((k % 8) != 7);
            check(tag, 16'({bus.IN_ACK, bus.SHIFT, bus.ADVANCE, bus.OUT_STROBE, bus.BUSY}),
                  16'({adv, shf, adv, st, 1'b1}));
            if (st) check({tag, "_step"}, 16'(bus.STEP_IDX), 16'(k % 8));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESET        = 1'b1;
        bus.ENABLE   = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.RATE_DIV = 8'd9;

        tbl[0]  = '{1'b0, 1'b1, 8'd9, 10'b0000000000, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'd9, 10'b0000000000, 3'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'd9, 10'b0000000000, 3'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'd9, 10'b1100000010, 3'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'd9, 10'b0000000010, 3'd0};
        tbl[5]  = '{1'b1, 1'b1, 8'd9, 10'b0000000010, 3'd0};
        tbl[6]  = '{1'b1, 1'b1, 8'd9, 10'b1011000010, 3'd0};
        tbl[7]  = '{1'b1, 1'b1, 8'd9, 10'b0000000010, 3'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'd9, 10'b0000000010, 3'd0};
        tbl[9]  = '{1'b1, 1'b1, 8'd9, 10'b0001100010, 3'd0};
        tbl[10] = '{1'b1, 1'b1, 8'd9, 10'b0000000010, 3'd0};

        do_reset();
        check("reset_outs", 16'(outs), 16'd0);
        check("reset_step", 16'(bus.STEP_IDX), 16'd0);

        // Priming with a WAIT_B stall; LOADC on c9, so the first strobe lands on c19.
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, tbl[i].en, tbl[i].iv, tbl[i].rd);
            check($sformatf("prime_outs_%0d", i), 16'(outs), 16'(tbl[i].exp_outs));
            check($sformatf("prime_step_%0d", i), 16'(bus.STEP_IDX), 16'(tbl[i].exp_step));
        end
        run_seg("rate9", 11, 110, 19, 10, 0, 8'd9);

        // RATE_DIV=0 clamps to a 4-cycle period, gapless across the advance at c38.
        start_run(8'd0);
        run_seg("rate0", 7, 50, 10, 4, 0, 8'd0);

        // RATE_DIV 9->19 mid-count: c16 keeps the old period, then 20-cycle periods.
        start_run(8'd9);
        run_seg("rdchg_a", 7, 11, 16, 10, 0, 8'd9);
        run_seg("rdchg_b", 12, 16, 16, 10, 0, 8'd19);
        run_seg("rdchg_c", 17, 60, 36, 20, 1, 8'd19);

        // RESET mid-RUN on the tick at c36.
        start_run(8'd9);
        run_seg("pre_rst", 7, 35, 16, 10, 0, 8'd9);
        cyc(1'b1, 1'b1, 1'b1, 8'd9);
        cyc(1'b0, 1'b1, 1'b1, 8'd9);
        check("midrun_reset_outs", 16'(outs), 16'd0);
        check("midrun_reset_step", 16'(bus.STEP_IDX), 16'd0);

        // Underrun at the 8th strobe (c86).
        start_run(8'd9);
        run_seg("pre_under", 7, 85, 16, 10, 0, 8'd9);
        cyc(1'b0, 1'b1, 1'b0, 8'd9);
        check("under_tick", 16'({bus.IN_ACK, bus.SHIFT, bus.ADVANCE, bus.OUT_STROBE}), 16'b0001);
`ifdef FOH_SEQ_UNDERRUN_HOLD_EN
        cyc(1'b0, 1'b1, 1'b0, 8'd9);
        check("hold_busy_under", 16'({bus.BUSY, bus.UNDERRUN}), 16'b11);
        for (int c = 88; c <= 97; c++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'd9);
            check($sformatf("hold_c%0d", c), 16'({bus.IN_ACK, bus.SHIFT, bus.ADVANCE, bus.OUT_STROBE}),
                  (c == 96) ? 16'b0001 : 16'b0000);
        end
        cyc(1'b0, 1'b1, 1'b1, 8'd9);
        check("hold_advance", 16'({bus.IN_ACK, bus.LOAD_A, bus.LOAD_B, bus.ADVANCE, bus.SHIFT}), 16'b11110);
        cyc(1'b0, 1'b0, 1'b0, 8'd9);
`else
        cyc(1'b0, 1'b1, 1'b0, 8'd9);
        check("under_idle", 16'({bus.BUSY, bus.OUT_STROBE, bus.UNDERRUN}), 16'b001);
        cyc(1'b0, 1'b1, 1'b0, 8'd9);
        check("under_sticky", 16'(outs), 16'b0000000001);
        cyc(1'b0, 1'b0, 1'b0, 8'd9);
`endif
        cyc(1'b0, 1'b1, 1'b0, 8'd9);
        check("under_cleared", 16'({bus.BUSY, bus.UNDERRUN}), 16'b00);

        // ENABLE dropped on the advance tick: no pop, IDLE next cycle.
        start_run(8'd9);
        run_seg("pre_en", 7, 85, 16, 10, 0, 8'd9);
        cyc(1'b0, 1'b0, 1'b1, 8'd9);
        check("en_drop_tick", 16'({bus.IN_ACK, bus.ADVANCE, bus.LOAD_A, bus.LOAD_B}), 16'b0000);
        cyc(1'b0, 1'b1, 1'b1, 8'd9);
        check("en_drop_idle", 16'(outs), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
